// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage placed directly in front of the instruction ROM.
// It owns the program counter, drives the ROM chip enable and address, and
// latches the ROM's combinational instruction word into the IF/ID pipeline
// register. It also handles stall, flush and branch redirect requests.
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   stall          hold PC and IF/ID register (downstream back-pressure)
//   flush          squash IF/ID contents and refetch the current PC
//   branch_en      one-cycle redirect request
//   branch_target  redirect address
//   rom_ce         ROM chip enable (registered)
//   rom_addr       ROM byte address, always equal to the PC
//   rom_inst       instruction word from the ROM for rom_addr
//   id_pc          PC of the instruction held in IF/ID
//   id_inst        instruction held in IF/ID
//   id_valid       IF/ID holds a real instruction
//   id_misalign    (IF_MISALIGN_TRAP_EN only) IF/ID entry is a misaligned
//                  fetch that the decode stage must trap on
//
// Build option:
//   IF_MISALIGN_TRAP_EN  when defined, misaligned branch targets are kept
//                        and reported through id_misalign; when undefined,
//                        the low two bits of a branch target are cleared.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int               ADDR_W   = 32,
    parameter int               INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
`ifdef IF_MISALIGN_TRAP_EN
    output logic              id_misalign,
`endif
    output logic              id_valid
);

    typedef enum logic {
        BOOT,
        FETCH
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] branch_load;
    logic              rom_ce_next;
    logic [ADDR_W-1:0] id_pc_next;
    logic [INST_W-1:0] id_inst_next;
    logic              id_valid_next;
    logic              misalign_next;
    logic              misalign_q;

    assign rom_addr = pc;

    // Address actually loaded into the PC on a redirect. Without the trap
    // option the target is forced to a word boundary.
`ifdef IF_MISALIGN_TRAP_EN
    assign branch_load = branch_target;
    assign id_misalign = misalign_q;
`else
    assign branch_load = branch_target & ~ADDR_W'(3);
`endif

    // Next-state and next-register computation. BOOT spends one cycle
    // turning the ROM on; only a redirect is honoured there because the
    // IF/ID register is already empty.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        rom_ce_next   = rom_ce;
        id_pc_next    = id_pc;
        id_inst_next  = id_inst;
        id_valid_next = id_valid;
        misalign_next = misalign_q;
        case (state)
            BOOT: begin
                rom_ce_next = 1'b1;
                state_next  = FETCH;
                if (branch_en) begin
                    pc_next = branch_load;
                end
            end
            FETCH: begin
                if (branch_en || flush) begin
                    if (branch_en) begin
                        pc_next = branch_load;
                    end
                    id_pc_next    = '0;
                    id_inst_next  = '0;
                    id_valid_next = 1'b0;
                    misalign_next = 1'b0;
                end else if (!stall) begin
                    id_pc_next    = pc;
                    id_inst_next  = rom_inst;
                    id_valid_next = 1'b1;
                    misalign_next = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
                    // A misaligned PC yields a trap marker instead of the
                    // ROM word so decode can raise the exception.
                    if (pc[1:0] != 2'b00) begin
                        id_inst_next  = '0;
                        misalign_next = 1'b1;
                    end
`endif
                    pc_next = pc + ADDR_W'(4);
                end
            end
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            rom_ce     <= 1'b0;
            id_pc      <= '0;
            id_inst    <= '0;
            id_valid   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            rom_ce     <= rom_ce_next;
            id_pc      <= id_pc_next;
            id_inst    <= id_inst_next;
            id_valid   <= id_valid_next;
            misalign_q <= misalign_next;
        end
    end

`ifndef IF_MISALIGN_TRAP_EN
    // Trap flag is never set without the option; keep it tied off.
    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage sitting directly upstream of the instruction ROM. It owns the PC register and drives the ROM chip-enable and address. It captures the ROM's combinational instruction word, already byte-ordered by the ROM, into the IF/ID pipeline register. It handles pipeline stall, flush and branch redirect from the control/EX logic.

Parameters:
ADDR_W, 32, width of PC and ROM address bus
INST_W, 32, width of instruction word
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
stall  input  1  hold PC and IF/ID register (downstream back-pressure)
flush  input  1  squash IF/ID contents, refetch current PC
branch_en  input  1  redirect request, valid for one cycle
branch_target  input  ADDR_W  redirect address
rom_ce  output  1  ROM chip enable (registered)
rom_addr  output  ADDR_W  ROM byte address, equals PC
rom_inst  input  INST_W  instruction from ROM, valid same cycle as rom_addr
id_pc  output  ADDR_W  PC of instruction in IF/ID register
id_inst  output  INST_W  instruction in IF/ID register
id_valid  output  1  IF/ID register holds a real instruction

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, rom_ce<=0, id_pc<=0, id_inst<=0, id_valid<=0, state<=BOOT.
- FSM has two states, BOOT and FETCH.
  - BOOT: lasts exactly one cycle after rst deasserts; rom_ce<=1; no IF/ID capture; pc held; -> FETCH.
  - FETCH: stays until rst.
- rom_addr = pc combinationally in all states. ROM output is ignored while rom_ce=0.
- FETCH update priority per edge: branch_en > flush > stall > normal.
  - branch_en=1: pc<=branch_target; id_valid<=0, id_inst<=0, id_pc<=0 (bubble). Overrides stall and flush in the same cycle.
  - flush=1 (no branch): pc held; IF/ID bubble as above. Current PC is refetched next cycle.
  - stall=1 (no branch/flush): pc, id_pc, id_inst, id_valid all hold.
  - normal: id_pc<=pc, id_inst<=rom_inst, id_valid<=1, pc<=pc+4.
- Latency: instruction at PC X appears on id_inst one edge after pc==X with no stall. First valid id_inst is 2 edges after reset release (BOOT, then first capture).
- Arithmetic: pc+4 is modulo 2^ADDR_W. At 32'hFFFF_FFFC it wraps to 0 with no flag.
- branch_target[1:0] != 0: see Optional Feature; by default the low two bits are forced to 0 when loaded.
- branch_en, flush and stall during BOOT: ignored except branch_en, which loads pc (no bubble needed, IF/ID already empty).
- rst asserted mid-operation, including during stall or branch: reset values take effect at that edge, unconditionally.

Optional Feature:
Macro: IF_MISALIGN_TRAP_EN
- Defined:
  - adds output id_misalign (1 bit, reset 0).
  - On branch_en with branch_target[1:0] != 0, pc loads branch_target unmodified.
  - The next normal capture sets id_misalign=1, id_inst=0 and id_valid=1; the downstream stage raises an exception.
  - id_misalign follows the IF/ID register under stall, flush and bubble rules.
- Not defined: port absent; branch_target low bits forced to 2'b00.

Test Plan:
- Reset release, ROM word at 0x0 = 32'h00500093, no stall -> rom_ce=1 after 1 edge; id_pc=0, id_inst=32'h00500093, id_valid=1 after 2nd edge; pc=4.
- Free run 4 cycles, then stall=1 for 3 cycles -> id_pc holds 0xC and pc holds 0x10 throughout the stall; on release, next edge id_pc=0x10.
- branch_en=1, target=0x40, with stall=1 in the same cycle -> next edge pc=0x40 and id_valid=0; following edge id_pc=0x40.
- flush=1 for one cycle at pc=0x8 -> id_valid=0; next edge id_pc=0x8, instruction refetched, no PC skip.
- Force pc=0xFFFF_FFFC via branch, free run -> id_pc=0xFFFF_FFFC, then pc=0x0; rst asserted mid-stall -> all outputs at reset values next edge.
- With IF_MISALIGN_TRAP_EN: branch to 0x42 -> id_misalign=1, id_inst=0, id_valid=1. Without the macro: pc=0x40, no misalign port.
